// File: rtl/io_trigger_sequencer.sv
// io_trigger_sequencer: delay/width/period/count pulse-train generator for a PL IO trigger line
module io_trigger_sequencer #(
  parameter int CNT_W = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             cfg_enable,
  input  logic             cfg_ext_mode,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             abort,
  input  logic             ext_trig,
  output logic             trig_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic             err_cfg
);
  typedef enum logic [2:0] {IDLE, ARM, DELAY, HIGH, LOW} state_t;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state;
  logic [SYNC_STAGES+1:0] sync;
  logic [CNT_W-1:0] cnt, sh_delay, sh_width, sh_period, sh_count, dly, wid, pulse_nxt;
  logic trig_edge, stop, accept, cfg_ok, last, go;
  // top sync bit is an extra history flop so the edge pulse lands SYNC_STAGES+1 cycles after the input
  assign trig_edge = sync[SYNC_STAGES] & ~sync[SYNC_STAGES+1];
  assign stop = abort | ~cfg_enable;
  assign accept = start & cfg_enable & ~abort;
  assign cfg_ok = cfg_width != '0 && cfg_period > cfg_width;
  assign last = sh_count != '0 && pulse_cnt == sh_count;
  assign pulse_nxt = &pulse_cnt ? pulse_cnt : pulse_cnt + ONE;
  // a train launches straight from IDLE (cfg values) or from ARM (shadow values)
  assign go = (state == IDLE) ? (accept & cfg_ok & ~cfg_ext_mode) : (state == ARM) & trig_edge;
  assign dly = (state == IDLE) ? cfg_delay : sh_delay;
  assign wid = (state == IDLE) ? cfg_width : sh_width;
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) sync <= '0;
    else sync <= {sync[SYNC_STAGES:0], ext_trig};
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= IDLE;
      trig_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pulse_cnt <= '0;
      err_cfg <= 1'b0;
      cnt <= '0;
      sh_delay <= '0;
      sh_width <= '0;
      sh_period <= '0;
      sh_count <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && stop) begin
        state <= IDLE;
        trig_out <= 1'b0;
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            sh_delay <= cfg_delay;
            sh_width <= cfg_width;
            sh_period <= cfg_period;
            sh_count <= cfg_count;
            err_cfg <= ~cfg_ok;
            if (cfg_ok) begin
              busy <= 1'b1;
              pulse_cnt <= '0;
              if (cfg_ext_mode) state <= ARM;
            end
          end
          DELAY: if (cnt == '0) begin
            state <= HIGH;
            trig_out <= 1'b1;
            cnt <= sh_width - ONE;
            pulse_cnt <= pulse_nxt;
          end else cnt <= cnt - ONE;
          HIGH: if (cnt == '0) begin
            trig_out <= 1'b0;
            if (last) begin
              state <= IDLE;
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              state <= LOW;
              cnt <= sh_period - sh_width - ONE;
            end
          end else cnt <= cnt - ONE;
          LOW: if (cnt == '0) begin
            state <= HIGH;
            trig_out <= 1'b1;
            cnt <= sh_width - ONE;
            pulse_cnt <= pulse_nxt;
          end else cnt <= cnt - ONE;
          default: ;
        endcase
        if (go) begin
          if (dly == '0) begin
            state <= HIGH;
            trig_out <= 1'b1;
            cnt <= wid - ONE;
            pulse_cnt <= ONE;
          end else begin
            state <= DELAY;
            cnt <= dly - ONE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_io_trigger_sequencer.sv
// tb_io_trigger_sequencer: directed plus random stimulus checked against a timeline model of the pulse train
module tb_io_trigger_sequencer;
  localparam int SS = 2;
  logic ACLK = 1'b0, ARESET = 1'b1;
  logic cfg_enable = 1'b1, cfg_ext_mode = 1'b0;
  logic [31:0] cfg_delay = '0, cfg_width = 32'd1, cfg_period = 32'd2, cfg_count = '0;
  logic start = 1'b0, abort = 1'b0, ext_trig = 1'b0;
  logic trig_out, busy, done, err_cfg;
  logic [31:0] pulse_cnt;
  always #5 ACLK = ~ACLK;

  io_trigger_sequencer #(.CNT_W(32), .SYNC_STAGES(SS)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_enable(cfg_enable), .cfg_ext_mode(cfg_ext_mode),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_period(cfg_period), .cfg_count(cfg_count),
    .start(start), .abort(abort), .ext_trig(ext_trig), .trig_out(trig_out), .busy(busy),
    .done(done), .pulse_cnt(pulse_cnt), .err_cfg(err_cfg)
  );

  int checks = 0, failures = 0, cyc = 0;
  bit m_active, m_arming, m_done, m_err;
  int m_t0, m_d, m_w, m_p, m_n, m_hold;
  bit ext_log[$];

  // a train is a timeline: first rise at m_t0, rises every m_p cycles, each high for m_w cycles
  function automatic bit m_trig(int n);
    return m_active && !m_arming && n >= m_t0 && ((n - m_t0) % m_p) < m_w;
  endfunction
  function automatic int m_pulses(int n);
    if (!m_active) return m_hold;
    if (m_arming || n < m_t0) return 0;
    return (n - m_t0) / m_p + 1;
  endfunction
  function automatic bit detect(int c);
    return c >= SS + 2 && ext_log[c-1-SS] && !ext_log[c-2-SS];
  endfunction

  task automatic model_edge();
    int c = cyc;
    int n = cyc + 1;
    if (ARESET) begin
      m_active = 0; m_arming = 0; m_done = 0; m_err = 0; m_hold = 0;
      ext_log.push_back(1'b0);
    end else begin
      ext_log.push_back(ext_trig);
      m_done = 0;
      if (m_active) begin
        if (abort || !cfg_enable) begin
          m_hold = m_pulses(c);
          m_active = 0;
        end else if (m_arming && detect(c)) begin
          m_arming = 0;
          m_t0 = n + m_d;
        end
      end else if (start && cfg_enable && !abort) begin
        if (cfg_width != 0 && cfg_period > cfg_width) begin
          m_err = 0; m_active = 1; m_arming = cfg_ext_mode;
          m_d = int'(cfg_delay); m_w = int'(cfg_width); m_p = int'(cfg_period); m_n = int'(cfg_count);
          m_t0 = n + m_d;
        end else m_err = 1;
      end
      if (m_active && !m_arming && m_n != 0 && n == m_t0 + (m_n - 1) * m_p + m_w) begin
        m_active = 0; m_hold = m_n; m_done = 1;
      end
    end
    cyc = n;
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", nm, cyc, a, e);
    end
  endtask
  task automatic chk_b(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b exp=%b", nm, cyc, a, e);
    end
  endtask

  task automatic compare();
    chk_b("trig_out", trig_out, m_trig(cyc));
    chk_b("busy", busy, m_active);
    chk_b("done", done, m_done);
    chk("pulse_cnt", pulse_cnt, m_pulses(cyc));
    chk_b("err_cfg", err_cfg, m_err);
  endtask

  task automatic tick();
    @(posedge ACLK);
    model_edge();
    @(negedge ACLK);
    compare();
  endtask

  task automatic set_cfg(input int d, input int w, input int p, input int n);
    cfg_delay = d; cfg_width = w; cfg_period = p; cfg_count = n;
  endtask

  logic [31:0] tv, bv, dv, pv;
  int hi;

  initial begin
    repeat (3) tick();
    chk_b("rst_trig", trig_out, 1'b0);
    chk("rst_pulse", pulse_cnt, 32'd0);
    ARESET = 1'b0;
    repeat (3) tick();

    // 3/2/5/3 train: highs at offsets 4-5, 9-10, 14-15, done at 16
    set_cfg(3, 2, 5, 3);
    start = 1'b1; tick(); start = 1'b0;
    tv = '0; bv = '0; dv = '0; pv = '0;
    for (int i = 0; i < 16; i++) begin
      tv[i] = trig_out; bv[i] = busy; dv[i] = done;
      if (i == 15) pv = pulse_cnt;
      tick();
    end
    chk("d1_trig_shape", tv, 32'h6318);
    chk("d1_busy_shape", bv, 32'h7FFF);
    chk("d1_done_shape", dv, 32'h8000);
    chk("d1_pulse_cnt", pv, 32'd3);

    set_cfg(0, 4, 4, 2);
    start = 1'b1; tick(); start = 1'b0;
    chk_b("d2_err_set", err_cfg, 1'b1);
    chk_b("d2_no_busy", busy, 1'b0);
    tick();
    chk_b("d2_no_trig", trig_out, 1'b0);
    set_cfg(0, 1, 2, 2);
    start = 1'b1; tick(); start = 1'b0;
    chk_b("d2_err_clr", err_cfg, 1'b0);
    chk_b("d2_rise", trig_out, 1'b1);
    repeat (6) tick();

    set_cfg(0, 1, 3, 0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 40 && pulse_cnt != 32'd7; i++) tick();
    chk("d3_reach7", pulse_cnt, 32'd7);
    abort = 1'b1; tick(); abort = 1'b0;
    chk_b("d3_abort_trig", trig_out, 1'b0);
    chk_b("d3_abort_busy", busy, 1'b0);
    chk("d3_hold", pulse_cnt, 32'd7);
    for (int i = 0; i < 5; i++) begin
      chk_b("d3_no_done", done, 1'b0);
      tick();
    end

    for (int i = 0; i < 8; i++) begin
      ext_trig = ~ext_trig;
      tick();
    end
    ext_trig = 1'b0;
    repeat (6) tick();
    chk_b("d4_idle_edges", busy, 1'b0);
    cfg_ext_mode = 1'b1; set_cfg(0, 1, 2, 1);
    start = 1'b1; tick(); start = 1'b0; cfg_ext_mode = 1'b0;
    repeat (3) tick();
    chk_b("d4_armed", busy, 1'b1);
    ext_trig = 1'b1;
    repeat (3) tick();
    chk_b("d4_pre_rise", trig_out, 1'b0);
    tick();
    chk_b("d4_rise", trig_out, 1'b1);
    ext_trig = 1'b0;
    repeat (4) tick();

    set_cfg(1, 2, 6, 3);
    start = 1'b1; tick(); start = 1'b0;
    cfg_width = 32'd6; cfg_period = 32'd7;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      hi += int'(trig_out);
      start = (i < 12) && (i % 4 == 0);
      tick();
    end
    start = 1'b0;
    chk("d5_high_cycles", hi, 32'd6);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk_b("d5_start_abort", busy, 1'b0);
    tick();

    set_cfg(0, 3, 5, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk_b("d6_high", trig_out, 1'b1);
    ARESET = 1'b1;
    #1;
    chk_b("d6_async_trig", trig_out, 1'b0);
    chk_b("d6_async_busy", busy, 1'b0);
    chk("d6_async_pulse", pulse_cnt, 32'd0);
    chk_b("d6_async_err", err_cfg, 1'b0);
    tick();
    ARESET = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    chk_b("d6_restart", trig_out, 1'b1);
    abort = 1'b1; tick(); abort = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      start = $urandom_range(0, 7) == 0;
      abort = $urandom_range(0, 39) == 0;
      cfg_enable = $urandom_range(0, 59) != 0;
      if ($urandom_range(0, 5) == 0) ext_trig = ~ext_trig;
      cfg_ext_mode = $urandom_range(0, 2) == 0;
      cfg_delay = $urandom_range(0, 4);
      cfg_width = $urandom_range(0, 4);
      cfg_period = cfg_width + $urandom_range(0, 4);
      cfg_count = $urandom_range(0, 4);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/io_trigger_sequencer.md
Name: io_trigger_sequencer

Overview:
- Programmable pulse-train generator that drives a PL IO trigger line from values held in the PL_IO_TriggerCtrl AXI4-Lite register file.
- Configuration arrives as plain register outputs: delay, width, period and count.
- Start, abort, external-trigger arming and status are handled here.
- Status returns to the register file for CPU readback.

Parameters:
CNT_W, 32, width of all timing and count fields and of the internal counters
SYNC_STAGES, 2, flip-flop stages in the ext_trig synchroniser (minimum 2)

Ports:
ACLK  in  1  system clock, all logic rising-edge
ARESET  in  1  asynchronous, active-high reset
cfg_enable  in  1  level; low forces abort and blocks start
cfg_ext_mode  in  1  1 = wait for external trigger edge after start
cfg_delay  in  CNT_W  cycles from start (or trigger edge) to first rising edge
cfg_width  in  CNT_W  high time in cycles
cfg_period  in  CNT_W  rising-to-rising time in cycles
cfg_count  in  CNT_W  pulses to emit; 0 = continuous until abort
start  in  1  single-cycle command pulse
abort  in  1  single-cycle command pulse
ext_trig  in  1  asynchronous external trigger input
trig_out  out  1  registered trigger output to IO
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on normal completion
pulse_cnt  out  CNT_W  rising edges emitted since last accepted start
err_cfg  out  1  sticky; invalid config at start

Behaviour:
- Reset values: trig_out=0, busy=0, done=0, pulse_cnt=0, err_cfg=0, state=IDLE, synchroniser=0.
- Reset mid-train: trig_out drops immediately (asynchronous).
- All outputs are registered.

States: IDLE, ARM, DELAY, HIGH, LOW.

IDLE:
- Start is accepted when start=1, cfg_enable=1 and abort=0.
- On acceptance, latch all cfg_* into shadow registers. Later cfg changes have no effect until the next start.
- Validity: cfg_width>=1 and cfg_period>cfg_width.
- Invalid config: err_cfg<=1, stay IDLE, pulse_cnt unchanged.
- Valid config: err_cfg<=0, pulse_cnt<=0, then go to ARM if ext_mode, else DELAY.

ARM:
- Wait for a rising edge of the synchronised ext_trig, then go to DELAY.
- Edge detection latency is SYNC_STAGES+1 cycles from the input edge.
- Edges seen in any other state are ignored.

DELAY:
- The counter loads the latched delay.
- With start accepted in cycle N (or edge detected in cycle N), trig_out first rises in cycle N+1+delay.
- delay=0 gives a rise in N+1.

HIGH:
- trig_out=1 for exactly width cycles.
- pulse_cnt increments in the cycle trig_out rises.

LOW:
- trig_out=0 for period-width cycles, then HIGH again.
- Rising edges are exactly period cycles apart.

Completion:
- When count!=0 and the final HIGH phase ends, go directly to IDLE; the final LOW phase is skipped.
- trig_out=0 and done=1 in that same cycle.
- busy falls the same cycle.

Abort (abort=1 or cfg_enable=0) in any non-IDLE state:
- Next cycle: IDLE, trig_out=0, busy=0.
- done is not asserted and pulse_cnt holds its value.

Simultaneous events:
- start while busy is ignored.
- start and abort in the same cycle: abort wins.
- abort in IDLE has no effect.

Counter arithmetic:
- Down-counters CNT_W wide; no wrap at the maximum field value.
- pulse_cnt saturates at all-ones in continuous mode.

Test Plan:
- delay=3, width=2, period=5, count=3, start at cycle 10 -> trig_out high in cycles 14-15, 19-20, 24-25; done in cycle 26; pulse_cnt=3; busy high cycles 11-25.
- width=4, period=4, start -> err_cfg=1, busy stays 0, trig_out stays 0; then width=1, period=2, start -> err_cfg=0, train runs.
- count=0, width=1, period=3, abort after 7 rising edges -> trig_out low the next cycle, pulse_cnt=7, done never asserted.
- ext_mode=1, delay=0, start then ext_trig edge at cycle 50 -> edge detected at cycle 53, first rise at cycle 54; ext_trig edges toggled while in IDLE produce nothing.
- cfg_width changed from 2 to 6 mid-train -> pulse widths remain 2; start pulses issued while busy are ignored; start+abort in the same cycle from IDLE -> stays IDLE.
- ARESET asserted while trig_out=1 -> trig_out=0 without a clock edge; all outputs at reset values; a new start after release works normally.
